// File: rtl/reg_read_port_pkg.sv
// Shared encodings for the register-file read port: 8086 reg-field codes,
// access-width codes and the byte-widening helper.
package reg_read_port_pkg;

    localparam logic [2:0] REG_AL = 3'b000;
    localparam logic [2:0] REG_CL = 3'b001;
    localparam logic [2:0] REG_DL = 3'b010;
    localparam logic [2:0] REG_BL = 3'b011;
    localparam logic [2:0] REG_AH = 3'b100;
    localparam logic [2:0] REG_CH = 3'b101;
    localparam logic [2:0] REG_DH = 3'b110;
    localparam logic [2:0] REG_BH = 3'b111;

    localparam logic [2:0] REG_AX = 3'b000;
    localparam logic [2:0] REG_CX = 3'b001;
    localparam logic [2:0] REG_DX = 3'b010;
    localparam logic [2:0] REG_BX = 3'b011;
    localparam logic [2:0] REG_SP = 3'b100;
    localparam logic [2:0] REG_BP = 3'b101;
    localparam logic [2:0] REG_SI = 3'b110;
    localparam logic [2:0] REG_DI = 3'b111;

    localparam logic W_BYTE = 1'b0;
    localparam logic W_WORD = 1'b1;

    function automatic logic [15:0] widen_byte(input logic [7:0] b, input logic sx);
        if (sx) begin
            return {{8{b[7]}}, b};
        end else begin
            return {8'h00, b};
        end
    endfunction

endpackage

// File: rtl/reg_read_fifo.sv
// Response queue for the register read port: DEPTH-entry circular buffer
// with occupancy count; full/empty derive from the registered count only.
module reg_read_fifo
    import reg_read_port_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       ready_o,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_s, pop_s;

    assign ready_o = (count_q != CW'(DEPTH));
    assign valid_o = (count_q != CW'(0));
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign push_s = push_i & ready_o;
    assign pop_s  = pop_i & valid_o;

    // Next pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset also wipes storage so nothing stale can resurface.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/reg_read_port.sv
// Register-file read port: selects the 8086 reg/W operand on acceptance and
// queues {operand, tag} for in-order return to the consumer.
module reg_read_port
    import reg_read_port_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [2:0]               REQ_REG,
    input  logic                     REQ_W,
    input  logic                     REQ_SX,
    input  logic [TAG_W-1:0]         REQ_TAG,
    input  logic [7:0]               AL,
    input  logic [7:0]               CL,
    input  logic [7:0]               DL,
    input  logic [7:0]               BL,
    input  logic [7:0]               AH,
    input  logic [7:0]               CH,
    input  logic [7:0]               DH,
    input  logic [7:0]               BH,
    input  logic [15:0]              SP,
    input  logic [15:0]              BP,
    input  logic [15:0]              SI,
    input  logic [15:0]              DI,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [15:0]              RSP_DATA,
    output logic [TAG_W-1:0]         RSP_TAG,
    output logic [$clog2(DEPTH):0]   COUNT
);

    logic [7:0]        byte_s;
    logic [15:0]       word_s;
    logic [15:0]       operand_s;
    logic [15+TAG_W:0] rsp_entry_s;

    // Operand select from the live register-file outputs at acceptance.
    always_comb begin
        byte_s    = 8'h00;
        word_s    = 16'h0000;
        operand_s = 16'h0000;
        case (REQ_REG)
            REG_AL:  byte_s = AL;
            REG_CL:  byte_s = CL;
            REG_DL:  byte_s = DL;
            REG_BL:  byte_s = BL;
            REG_AH:  byte_s = AH;
            REG_CH:  byte_s = CH;
            REG_DH:  byte_s = DH;
            REG_BH:  byte_s = BH;
            default: byte_s = 8'h00;
        endcase
        case (REQ_REG)
            REG_AX:  word_s = {AH, AL};
            REG_CX:  word_s = {CH, CL};
            REG_DX:  word_s = {DH, DL};
            REG_BX:  word_s = {BH, BL};
            REG_SP:  word_s = SP;
            REG_BP:  word_s = BP;
            REG_SI:  word_s = SI;
            REG_DI:  word_s = DI;
            default: word_s = 16'h0000;
        endcase
        if (REQ_W == W_WORD) begin
            operand_s = word_s;
        end else begin
            operand_s = widen_byte(byte_s, REQ_SX);
        end
    end

    reg_read_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16 + TAG_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (REQ_VALID),
        .data_i  ({operand_s, REQ_TAG}),
        .ready_o (REQ_READY),
        .pop_i   (RSP_READY),
        .valid_o (RSP_VALID),
        .data_o  (rsp_entry_s),
        .count_o (COUNT)
    );

    assign RSP_DATA = rsp_entry_s[15+TAG_W:TAG_W];
    assign RSP_TAG  = rsp_entry_s[TAG_W-1:0];

endmodule
